accum_drain: RTL and testbench
==============================

ACCUM_DRAIN -- requirements
Module: accum_drain

Interface
REQ-001 Parameter DEPTH, default 16, number of accumulator entries per column.
REQ-002 Parameter ADDR_W, default 4, accumulator address width (log2 DEPTH).
REQ-003 Parameter DATA_W, default 8, accumulator and output data width.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 io_start  input  1  drain request; sampled only in IDLE.
REQ-007 io_count  input  ADDR_W+1  number of entries to drain, sampled with io_start; 0 SHALL mean DEPTH.
REQ-008 io_relu_en  input  1  apply ReLU to drained values; sampled with io_start.
REQ-009 io_clear_after  input  1  clear the accumulator column after the drain; sampled with io_start.
REQ-010 io_acc_rd_en  output  1  read enable to accumulator column.
REQ-011 io_acc_rd_addr  output  ADDR_W  read address to accumulator column.
REQ-012 io_acc_rd_data  input  DATA_W  accumulator read data, valid combinationally in the same cycle as rd_en/rd_addr.
REQ-013 io_acc_clear  output  1  one-cycle clear pulse to accumulator column.
REQ-014 io_out_valid  output  1  output beat valid.
REQ-015 io_out_ready  input  1  downstream accepts beat.
REQ-016 io_out_data  output  DATA_W  drained (post-ReLU) value.
REQ-017 io_out_addr  output  ADDR_W  accumulator address the beat came from.
REQ-018 io_out_last  output  1  marks final beat of a drain.
REQ-019 io_busy  output  1  high in any state other than IDLE.
REQ-020 io_done  output  1  one-cycle pulse on drain completion.

Function
REQ-021 FSM states SHALL be IDLE, DRAIN, FLUSH, CLEAR, DONE.
REQ-022 IDLE: io_start=1 SHALL latch count/relu_en/clear_after, set ptr=0, go to DRAIN next cycle; io_start outside IDLE SHALL be ignored.
REQ-023 Output register is "free" when io_out_valid=0 or io_out_ready=1 in that cycle.
REQ-024 DRAIN: when free and ptr<count, SHALL assert io_acc_rd_en=1, io_acc_rd_addr=ptr, load out register with processed io_acc_rd_data, io_out_addr=ptr, io_out_last=(ptr==count-1), set io_out_valid=1, increment ptr.
REQ-025 DRAIN: when not free, io_acc_rd_en SHALL be 0 and out_data/addr/last/valid SHALL hold stable.
REQ-026 Beat transfer occurs when io_out_valid & io_out_ready; a transfer with no new load SHALL clear io_out_valid.
REQ-027 Throughput SHALL be one beat per cycle with io_out_ready held high; first beat valid two cycles after the io_start cycle.
REQ-028 After loading the last entry, FSM SHALL go to FLUSH and hold until the last beat transfers.
REQ-029 FLUSH exit: to CLEAR if clear_after latched, else to DONE.
REQ-030 CLEAR: io_acc_clear=1 for exactly one cycle, then DONE; io_acc_clear SHALL never coincide with io_acc_rd_en.
REQ-031 DONE: io_done=1 for one cycle, then IDLE.
REQ-032 ReLU: value is signed two's complement; with relu_en=1 and MSB=1 output SHALL be 0, otherwise value passes unchanged; no saturation or width change.
REQ-033 io_acc_rd_addr SHALL equal ptr (truncated to ADDR_W) in all states; io_acc_rd_en SHALL be 0 outside DRAIN loads.
REQ-034 count>DEPTH SHALL be treated as DEPTH.
REQ-035 io_out_ready low for any duration SHALL lose, duplicate, or reorder no beat.

Reset
REQ-036 reset=0 at a rising edge SHALL force IDLE, ptr=0, io_out_valid=0, io_out_last=0, io_out_data=0, io_out_addr=0, io_busy=0, io_done=0, io_acc_clear=0, io_acc_rd_en=0.
REQ-037 reset asserted mid-drain SHALL abort with no io_acc_clear and no io_done pulse.

Verification
REQ-038 Accum holds 0..15 = 1,2,..,16; start count=0, relu off, ready=1 -> 16 beats data 1..16, addr 0..15, last on beat 16, done 1 cycle after last beat; no clear.
REQ-039 Entry 3 = 0xF6 (-10), entry 5 = 0x7F; start count=8, relu on -> beat 3 data 0x00, beat 5 data 0x7F, last on addr 7.
REQ-040 count=4, ready toggled 1,0,0,1,0,1,... -> exactly 4 beats in order addr 0..3, data stable while valid & !ready.
REQ-041 count=2, clear_after=1 -> io_acc_clear high exactly one cycle after addr-1 beat transfers, then done; re-drain returns all zeros.
REQ-042 io_start pulsed again while busy -> ignored; reset=0 during beat 5 of 16 -> next cycle out_valid=0, busy=0, no done, no clear.

Source files
------------

// File: rtl/accum_drain.sv
`default_nettype none
// ============================================================================
//  Module   : accum_drain
//  Purpose  : Streams one accumulator column out through an optional ReLU,
//             with backpressure, then optionally clears the column.
//  Revision : 1.0
// ============================================================================
module accum_drain #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic [ADDR_W:0]   io_count,
    input  logic              io_relu_en,
    input  logic              io_clear_after,
    output logic              io_acc_rd_en,
    output logic [ADDR_W-1:0] io_acc_rd_addr,
    input  logic [DATA_W-1:0] io_acc_rd_data,
    output logic              io_acc_clear,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [DATA_W-1:0] io_out_data,
    output logic [ADDR_W-1:0] io_out_addr,
    output logic              io_out_last,
    output logic              io_busy,
    output logic              io_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_FLUSH = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W:0]     r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_relu;
    logic                r_clear_after;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;

    logic                w_free;
    logic                w_load;
    logic                w_last;
    logic [ADDR_W:0]     w_count_eff;
    logic [DATA_W-1:0]   w_proc_data;

    // A zero or oversized request drains the whole column.
    assign w_count_eff = ((io_count == '0) || (io_count > c_depth)) ? c_depth : io_count;
    assign w_free      = !r_out_valid || io_out_ready;
    assign w_load      = (r_state == S_DRAIN) && w_free && (r_ptr < r_count);
    assign w_last      = (r_ptr == (r_count - c_one));
    assign w_proc_data = (r_relu && io_acc_rd_data[DATA_W-1]) ? '0 : io_acc_rd_data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_count       <= '0;
            r_relu        <= 1'b0;
            r_clear_after <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_data    <= '0;
            r_out_addr    <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && io_start) begin
                r_count       <= w_count_eff;
                r_relu        <= io_relu_en;
                r_clear_after <= io_clear_after;
                r_ptr         <= '0;
            end else if (w_load) begin
                r_ptr <= r_ptr + c_one;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_proc_data;
                r_out_addr  <= r_ptr[ADDR_W-1:0];
                r_out_last  <= w_last;
            end else if (r_out_valid && io_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        io_acc_rd_en = 1'b0;
        io_acc_clear = 1'b0;
        io_done      = 1'b0;
        io_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (io_start) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                io_acc_rd_en = w_load;
                if (w_load && w_last) w_next_state = S_FLUSH;
            end
            S_FLUSH: begin
                // Wait for the final beat to leave the output register.
                if (r_out_valid && io_out_ready)
                    w_next_state = r_clear_after ? S_CLEAR : S_DONE;
            end
            S_CLEAR: begin
                io_acc_clear = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                io_done      = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign io_acc_rd_addr = r_ptr[ADDR_W-1:0];
    assign io_out_valid   = r_out_valid;
    assign io_out_data    = r_out_data;
    assign io_out_addr    = r_out_addr;
    assign io_out_last    = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_accum_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accum_drain
//  Purpose  : Scoreboard bench for accum_drain with an accumulator model.
//  Revision : 1.0
// ============================================================================
module tb_accum_drain;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] addr;
        logic       last;
    } beat_t;

    logic       clock;
    logic       reset;
    logic       io_start;
    logic [4:0] io_count;
    logic       io_relu_en;
    logic       io_clear_after;
    logic       io_acc_rd_en;
    logic [3:0] io_acc_rd_addr;
    logic [7:0] io_acc_rd_data;
    logic       io_acc_clear;
    logic       io_out_valid;
    logic       io_out_ready;
    logic [7:0] io_out_data;
    logic [3:0] io_out_addr;
    logic       io_out_last;
    logic       io_busy;
    logic       io_done;

    logic [7:0] mem [16];
    beat_t      sb [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         beats = 0;
    int         clears = 0;
    int         dones = 0;
    int         xfer_cyc = -1;
    int         clear_cyc = -1;
    int         done_cyc = -1;
    int         last_addr = -1;
    bit         prev_v = 0;
    bit         prev_r = 0;
    beat_t      prev_b;
    bit         ready_mode = 0;
    int         pidx = 0;
    bit         pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    assign io_acc_rd_data = mem[io_acc_rd_addr];

    accum_drain #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_start       (io_start),
        .io_count       (io_count),
        .io_relu_en     (io_relu_en),
        .io_clear_after (io_clear_after),
        .io_acc_rd_en   (io_acc_rd_en),
        .io_acc_rd_addr (io_acc_rd_addr),
        .io_acc_rd_data (io_acc_rd_data),
        .io_acc_clear   (io_acc_clear),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_data    (io_out_data),
        .io_out_addr    (io_out_addr),
        .io_out_last    (io_out_last),
        .io_busy        (io_busy),
        .io_done        (io_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard pop, stall stability and accumulator-clear model, once per negedge.
    task automatic observe();
        beat_t got;
        beat_t exp;
        if (!reset) begin
            prev_v = 1'b0;
            return;
        end
        got = '{data: io_out_data, addr: io_out_addr, last: io_out_last};
        if (io_acc_clear) begin
            vectors++;
            if (io_acc_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL clear_vs_rd_en: rd_en=%b expected 0 while clear", io_acc_rd_en);
            end
        end
        if (prev_v && !prev_r) begin
            vectors++;
            if (io_out_valid !== 1'b1 || got !== prev_b) begin
                miscompares++;
                $display("FAIL stall_hold: valid=%b beat=%h expected valid=1 beat=%h",
                         io_out_valid, got, prev_b);
            end
        end
        if (io_out_valid === 1'b1 && io_out_ready === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got %h with empty scoreboard", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL beat: got data=%h addr=%h last=%b expected data=%h addr=%h last=%b",
                             got.data, got.addr, got.last, exp.data, exp.addr, exp.last);
                end
            end
            xfer_cyc = cyc;
            beats++;
            if (io_out_last === 1'b1) last_addr = int'(io_out_addr);
        end
        if (io_acc_clear === 1'b1) begin
            clears++;
            clear_cyc = cyc;
            foreach (mem[i]) mem[i] = 8'h00;
        end
        if (io_done === 1'b1) begin
            dones++;
            done_cyc = cyc;
        end
        prev_v = io_out_valid;
        prev_r = io_out_ready;
        prev_b = got;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (ready_mode) begin
            io_out_ready = pat[pidx];
            pidx = (pidx + 1) % 8;
        end
        @(negedge clock);
        observe();
    endtask

    task automatic start_drain(input int cnt, input bit relu, input bit clr);
        int n;
        beat_t b;
        n = (cnt == 0 || cnt > 16) ? 16 : cnt;
        for (int i = 0; i < n; i++) begin
            b.data = (relu && mem[i][7]) ? 8'h00 : mem[i];
            b.addr = 4'(i);
            b.last = (i == n - 1);
            sb.push_back(b);
        end
        io_count       = 5'(cnt);
        io_relu_en     = relu;
        io_clear_after = clr;
        io_start       = 1'b1;
        tick();
        io_start       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (io_done === 1'b1) got = 1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL done_timeout: no io_done within %0d cycles, expected a pulse", budget);
        end
    endtask

    task automatic fill_ramp();
        foreach (mem[i]) mem[i] = 8'(i + 1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vectors += 8;
        if (io_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", io_out_valid); end
        if (io_out_last !== 1'b0) begin miscompares++; $display("FAIL rst_last: got %b expected 0", io_out_last); end
        if (io_out_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %h expected 00", io_out_data); end
        if (io_out_addr !== 4'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", io_out_addr); end
        if (io_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", io_busy); end
        if (io_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", io_done); end
        if (io_acc_clear !== 1'b0) begin miscompares++; $display("FAIL rst_clear: got %b expected 0", io_acc_clear); end
        if (io_acc_rd_en !== 1'b0 || io_acc_rd_addr !== 4'h0) begin
            miscompares++;
            $display("FAIL rst_rd: rd_en=%b addr=%h expected 0/0", io_acc_rd_en, io_acc_rd_addr);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_full_drain();
        int c0 = clears;
        int b0 = beats;
        fill_ramp();
        start_drain(0, 0, 0);
        vectors++;
        if (io_out_valid !== 1'b0 || io_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_early: valid=%b busy=%b expected 0/1", io_out_valid, io_busy);
        end
        tick();
        vectors++;
        if (io_out_valid !== 1'b1 || io_out_addr !== 4'h0 || io_out_data !== 8'h01) begin
            miscompares++;
            $display("FAIL latency_first: valid=%b addr=%h data=%h expected 1/0/01",
                     io_out_valid, io_out_addr, io_out_data);
        end
        wait_done(40);
        vectors += 4;
        if (beats - b0 !== 16) begin miscompares++; $display("FAIL full_beats: got %0d expected 16", beats - b0); end
        if (done_cyc !== xfer_cyc + 1) begin
            miscompares++;
            $display("FAIL full_done_time: done at %0d expected %0d", done_cyc, xfer_cyc + 1);
        end
        if (clears !== c0) begin miscompares++; $display("FAIL full_noclear: got %0d clears expected 0", clears - c0); end
        if (last_addr !== 15) begin miscompares++; $display("FAIL full_last: got addr %0d expected 15", last_addr); end
        tick();
        vectors++;
        if (io_done !== 1'b0 || io_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b busy=%b expected 0/0", io_done, io_busy);
        end
    endtask

    task automatic test_relu();
        fill_ramp();
        mem[3] = 8'hF6;
        mem[5] = 8'h7F;
        start_drain(8, 1, 0);
        wait_done(40);
        vectors += 2;
        if (sb.size() !== 0) begin miscompares++; $display("FAIL relu_left: %0d beats outstanding expected 0", sb.size()); end
        if (last_addr !== 7) begin miscompares++; $display("FAIL relu_last: got addr %0d expected 7", last_addr); end
        tick();
    endtask

    task automatic test_backpressure();
        int b0 = beats;
        fill_ramp();
        ready_mode = 1;
        pidx = 0;
        start_drain(4, 0, 0);
        wait_done(80);
        ready_mode = 0;
        io_out_ready = 1'b1;
        vectors += 2;
        if (beats - b0 !== 4) begin miscompares++; $display("FAIL bp_beats: got %0d expected 4", beats - b0); end
        if (sb.size() !== 0) begin miscompares++; $display("FAIL bp_left: %0d outstanding expected 0", sb.size()); end
        tick();
    endtask

    task automatic test_clear();
        int c0 = clears;
        foreach (mem[i]) mem[i] = 8'(8'h21 + i);
        start_drain(2, 0, 1);
        wait_done(40);
        vectors += 3;
        if (clears - c0 !== 1) begin miscompares++; $display("FAIL clr_count: got %0d expected 1", clears - c0); end
        if (clear_cyc !== xfer_cyc + 1) begin
            miscompares++;
            $display("FAIL clr_time: clear at %0d expected %0d", clear_cyc, xfer_cyc + 1);
        end
        if (done_cyc !== clear_cyc + 1) begin
            miscompares++;
            $display("FAIL clr_done: done at %0d expected %0d", done_cyc, clear_cyc + 1);
        end
        tick();
        start_drain(0, 0, 0);
        wait_done(40);
        vectors++;
        if (sb.size() !== 0) begin miscompares++; $display("FAIL redrain_left: %0d outstanding expected 0", sb.size()); end
        tick();
    endtask

    task automatic test_count_edges();
        int b0 = beats;
        fill_ramp();
        start_drain(20, 0, 0);
        wait_done(40);
        vectors++;
        if (beats - b0 !== 16) begin miscompares++; $display("FAIL over_beats: got %0d expected 16", beats - b0); end
        tick();
        b0 = beats;
        start_drain(1, 0, 0);
        wait_done(20);
        vectors += 2;
        if (beats - b0 !== 1) begin miscompares++; $display("FAIL one_beats: got %0d expected 1", beats - b0); end
        if (last_addr !== 0) begin miscompares++; $display("FAIL one_last: got addr %0d expected 0", last_addr); end
        tick();
    endtask

    task automatic test_abort();
        int  c0 = clears;
        int  d0 = dones;
        bit  found = 0;
        fill_ramp();
        start_drain(16, 0, 0);
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (io_out_valid === 1'b1 && io_out_addr === 4'h1) found = 1;
        end
        io_count = 5'd3;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (io_out_valid === 1'b1 && io_out_addr === 4'h4) found = 1;
            else tick();
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL abort_beat5: beat addr 4 not seen, expected it"); end
        reset = 1'b0;
        tick();
        vectors++;
        if (io_out_valid !== 1'b0 || io_busy !== 1'b0 || io_done !== 1'b0 || io_acc_clear !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: valid=%b busy=%b done=%b clear=%b expected all 0",
                     io_out_valid, io_busy, io_done, io_acc_clear);
        end
        reset = 1'b1;
        sb.delete();
        for (int k = 0; k < 5; k++) tick();
        vectors++;
        if (dones !== d0 || clears !== c0 || io_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet: dones=%0d clears=%0d busy=%b expected 0/0/0",
                     dones - d0, clears - c0, io_busy);
        end
    endtask

    initial begin
        reset          = 1'b0;
        io_start       = 1'b0;
        io_count       = '0;
        io_relu_en     = 1'b0;
        io_clear_after = 1'b0;
        io_out_ready   = 1'b1;
        foreach (mem[i]) mem[i] = 8'h00;
        test_reset();
        test_full_drain();
        test_relu();
        test_backpressure();
        test_clear();
        test_count_edges();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
